phase_arbiter: RTL and testbench

PHASE_ARBITER -- requirements
Module: phase_arbiter

---
 rtl/phase_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_phase_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_arbiter.sv
// Three-requester round-robin front end for a single shared phase engine.
// Optional BUSY timeout with per-requester error pulse: define PHASE_ARB_TIMEOUT_EN.

module phase_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 63
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] req0_i,
    input  logic [31:0] req0_q,
    input  logic        req0_stb,
    input  logic [31:0] req1_i,
    input  logic [31:0] req1_q,
    input  logic        req1_stb,
    input  logic [31:0] req2_i,
    input  logic [31:0] req2_q,
    input  logic        req2_stb,
    output logic [31:0] req0_phase,
    output logic        req0_phase_stb,
    output logic        req0_pending,
    output logic        req0_err,
    output logic [31:0] req1_phase,
    output logic        req1_phase_stb,
    output logic        req1_pending,
    output logic        req1_err,
    output logic [31:0] req2_phase,
    output logic        req2_phase_stb,
    output logic        req2_pending,
    output logic        req2_err,
    output logic [2:0]  overflow,
    output logic [31:0] phase_in_i,
    output logic [31:0] phase_in_q,
    output logic        phase_in_stb,
    input  logic [31:0] phase_out,
    input  logic        phase_out_stb
);
    localparam int unsigned N_REQ  = 3;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 2;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("phase_arbiter: TIMEOUT_CYCLES must be in 2..255");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

    state_t             state;
    logic [DATA_W-1:0]  in_i [N_REQ];
    logic [DATA_W-1:0]  in_q [N_REQ];
    logic [N_REQ-1:0]   stb_vec;
    logic [N_REQ-1:0]   slot_valid;
    logic [DATA_W-1:0]  slot_i [N_REQ];
    logic [DATA_W-1:0]  slot_q [N_REQ];
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   last_grant;
    logic [DATA_W-1:0]  phase_r [N_REQ];
    logic [N_REQ-1:0]   phase_stb_r;
    logic [N_REQ-1:0]   overflow_r;
    logic [N_REQ-1:0]   accept;
    logic [N_REQ-1:0]   req_vec;
    logic               grant_valid;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   cand;

    assign in_i[0] = req0_i;
    assign in_i[1] = req1_i;
    assign in_i[2] = req2_i;
    assign in_q[0] = req0_q;
    assign in_q[1] = req1_q;
    assign in_q[2] = req2_q;
    assign stb_vec = {req2_stb, req1_stb, req0_stb};

    assign req0_phase     = phase_r[0];
    assign req1_phase     = phase_r[1];
    assign req2_phase     = phase_r[2];
    assign req0_phase_stb = phase_stb_r[0];
    assign req1_phase_stb = phase_stb_r[1];
    assign req2_phase_stb = phase_stb_r[2];
    assign req0_pending   = slot_valid[0];
    assign req1_pending   = slot_valid[1];
    assign req2_pending   = slot_valid[2];
    assign overflow       = overflow_r;

`ifdef PHASE_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = 8;

    logic [CNT_W-1:0] busy_cnt;
    logic [N_REQ-1:0] err_r;

    assign req0_err = err_r[0];
    assign req1_err = err_r[1];
    assign req2_err = err_r[2];
`else
    assign req0_err = 1'b0;
    assign req1_err = 1'b0;
    assign req2_err = 1'b0;
`endif

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + IDX_W'(1);
    endfunction

    // A slot being issued this cycle counts as empty, so a same-cycle strobe refills it.
    always_comb begin
        accept = '0;
        for (int n = 0; n < N_REQ; n++) begin
            accept[n] = stb_vec[n] &
                        (~slot_valid[n] | ((state == ISSUE) & (owner == IDX_W'(n))));
        end
    end

    // Round-robin search starting after the last granted requester.
    always_comb begin
        req_vec     = slot_valid | stb_vec;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = last_grant;
        for (int k = 0; k < N_REQ; k++) begin
            cand = next_idx(cand);
            if (!grant_valid && req_vec[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            owner        <= '0;
            last_grant   <= IDX_W'(N_REQ - 1);
            slot_valid   <= '0;
            phase_stb_r  <= '0;
            overflow_r   <= '0;
            phase_in_i   <= '0;
            phase_in_q   <= '0;
            phase_in_stb <= 1'b0;
            for (int n = 0; n < N_REQ; n++) begin
                slot_i[n]  <= '0;
                slot_q[n]  <= '0;
                phase_r[n] <= '0;
            end
`ifdef PHASE_ARB_TIMEOUT_EN
            busy_cnt <= '0;
            err_r    <= '0;
`endif
        end else begin
            phase_in_stb <= 1'b0;
            phase_stb_r  <= '0;
`ifdef PHASE_ARB_TIMEOUT_EN
            err_r        <= '0;
`endif
            if (enable) begin
                overflow_r <= overflow_r | (stb_vec & ~accept);
                case (state)
                    IDLE: begin
                        if (grant_valid) begin
                            owner      <= grant_idx;
                            last_grant <= grant_idx;
                            state      <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        phase_in_i         <= slot_i[owner];
                        phase_in_q         <= slot_q[owner];
                        phase_in_stb       <= 1'b1;
                        slot_valid[owner]  <= 1'b0;
                        state              <= BUSY;
`ifdef PHASE_ARB_TIMEOUT_EN
                        busy_cnt           <= '0;
`endif
                    end
                    BUSY: begin
                        if (phase_out_stb) begin
                            phase_r[owner]     <= phase_out;
                            phase_stb_r[owner] <= 1'b1;
                            state              <= IDLE;
                        end
`ifdef PHASE_ARB_TIMEOUT_EN
                        else if (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                            err_r[owner] <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            busy_cnt <= busy_cnt + CNT_W'(1);
                        end
`endif
                    end
                    default: state <= IDLE;
                endcase
                for (int n = 0; n < N_REQ; n++) begin
                    if (accept[n]) begin
                        slot_valid[n] <= 1'b1;
                        slot_i[n]     <= in_i[n];
                        slot_q[n]     <= in_q[n];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_phase_arbiter.sv
// Bench for phase_arbiter: directed scenarios plus random traffic, every cycle
// compared against a requirement-level reference model.

module tb_phase_arbiter;
    localparam int unsigned T = 8;

    logic        clock = 1'b0;
    logic        reset, enable;
    logic [31:0] r_i [3];
    logic [31:0] r_q [3];
    logic [2:0]  r_stb;
    logic [31:0] o_phase [3];
    logic [2:0]  o_pstb, o_pend, o_err, overflow;
    logic [31:0] pin_i, pin_q, phase_out;
    logic        pin_stb, phase_out_stb;

    always #5 clock = ~clock;

    phase_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .req0_i(r_i[0]), .req0_q(r_q[0]), .req0_stb(r_stb[0]),
        .req1_i(r_i[1]), .req1_q(r_q[1]), .req1_stb(r_stb[1]),
        .req2_i(r_i[2]), .req2_q(r_q[2]), .req2_stb(r_stb[2]),
        .req0_phase(o_phase[0]), .req0_phase_stb(o_pstb[0]), .req0_pending(o_pend[0]), .req0_err(o_err[0]),
        .req1_phase(o_phase[1]), .req1_phase_stb(o_pstb[1]), .req1_pending(o_pend[1]), .req1_err(o_err[1]),
        .req2_phase(o_phase[2]), .req2_phase_stb(o_pstb[2]), .req2_pending(o_pend[2]), .req2_err(o_err[2]),
        .overflow(overflow),
        .phase_in_i(pin_i), .phase_in_q(pin_q), .phase_in_stb(pin_stb),
        .phase_out(phase_out), .phase_out_stb(phase_out_stb)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: holding slots, who owns the engine, and what it is waiting for.
    bit [2:0]    m_valid;
    logic [31:0] m_si [3];
    logic [31:0] m_sq [3];
    int          m_last, m_owner;
    int          m_mode;          // 0: engine free, 1: grant made, issue next, 2: awaiting result
`ifdef PHASE_ARB_TIMEOUT_EN
    int          m_cnt;
`endif
    bit          e_in_stb;
    logic [31:0] e_in_i, e_in_q;
    logic [31:0] e_phase [3];
    bit [2:0]    e_pstb, e_err, e_ovf;

    // Environment state
    int          cyc = 0;
    bit          auto_eng = 1'b1, rand_eng = 1'b0, rand_en = 1'b0;
    int          eng_wait = 0, eng_delay = 3;
    logic [31:0] eng_val = '0;
    int          in_cyc_q[$], out_cyc_q[$];
    logic [31:0] in_log[$];
    int          pstb_cnt [3], last_pstb [3], err_cnt [3], last_err [3];
    int          last_out_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit [2:0] acc;
        bit       found;
        if (reset) begin
            m_valid = '0; m_last = 2; m_owner = 0; m_mode = 0;
            e_in_stb = 0; e_in_i = '0; e_in_q = '0; e_pstb = '0; e_err = '0; e_ovf = '0;
            for (int n = 0; n < 3; n++) begin
                m_si[n] = '0; m_sq[n] = '0; e_phase[n] = '0;
            end
        end else begin
            e_in_stb = 0; e_pstb = '0; e_err = '0;
            if (enable) begin
                for (int n = 0; n < 3; n++)
                    acc[n] = r_stb[n] && (!m_valid[n] || (m_mode == 1 && m_owner == n));
                e_ovf = e_ovf | (r_stb & ~acc);
                if (m_mode == 0) begin
                    found = 0;
                    for (int k = 1; k <= 3; k++) begin
                        int c;
                        c = (m_last + k) % 3;
                        if (!found && (m_valid[c] || r_stb[c])) begin
                            found = 1; m_owner = c; m_last = c; m_mode = 1;
                        end
                    end
                end else if (m_mode == 1) begin
                    e_in_i = m_si[m_owner]; e_in_q = m_sq[m_owner]; e_in_stb = 1;
                    m_valid[m_owner] = 0; m_mode = 2;
`ifdef PHASE_ARB_TIMEOUT_EN
                    m_cnt = 0;
`endif
                end else begin
                    if (phase_out_stb) begin
                        e_phase[m_owner] = phase_out; e_pstb[m_owner] = 1; m_mode = 0;
                    end
`ifdef PHASE_ARB_TIMEOUT_EN
                    else begin
                        m_cnt++;
                        if (m_cnt == int'(T)) begin
                            e_err[m_owner] = 1; m_mode = 0;
                        end
                    end
`endif
                end
                for (int n = 0; n < 3; n++)
                    if (acc[n]) begin
                        m_valid[n] = 1; m_si[n] = r_i[n]; m_sq[n] = r_q[n];
                    end
            end
        end
    endtask

    task automatic check_all();
        chk("phase_in_stb", 32'(pin_stb), 32'(e_in_stb));
        chk("phase_in_i", pin_i, e_in_i);
        chk("phase_in_q", pin_q, e_in_q);
        chk("overflow", 32'(overflow), 32'(e_ovf));
        for (int n = 0; n < 3; n++) begin
            chk($sformatf("req%0d_phase", n), o_phase[n], e_phase[n]);
            chk($sformatf("req%0d_phase_stb", n), 32'(o_pstb[n]), 32'(e_pstb[n]));
            chk($sformatf("req%0d_pending", n), 32'(o_pend[n]), 32'(m_valid[n]));
            chk($sformatf("req%0d_err", n), 32'(o_err[n]), 32'(e_err[n]));
        end
    endtask

    task automatic tick();
        if (auto_eng) begin
            phase_out_stb = (eng_wait == 1);
            phase_out     = eng_val;
        end
        if (rand_en) enable = phase_out_stb ? 1'b1 : ($urandom_range(0, 7) != 0);
        if (phase_out_stb) begin
            out_cyc_q.push_back(cyc);
            last_out_cyc = cyc;
        end
        model_step();
        @(posedge clock);
        #1;
        cyc++;
        if (eng_wait > 0) eng_wait--;
        if (e_in_stb) begin
            if (rand_eng) begin
                eng_delay = $urandom_range(1, 6);
                eng_val   = $urandom();
            end
            eng_wait = eng_delay + 1;
        end
        if (pin_stb) begin
            in_cyc_q.push_back(cyc);
            in_log.push_back(pin_i);
        end
        for (int n = 0; n < 3; n++) begin
            if (o_pstb[n]) begin pstb_cnt[n]++; last_pstb[n] = cyc; end
            if (o_err[n])  begin err_cnt[n]++;  last_err[n]  = cyc; end
        end
        check_all();
        r_stb = '0;
    endtask

    task automatic clear_logs();
        in_cyc_q.delete(); out_cyc_q.delete(); in_log.delete();
        last_out_cyc = -1;
        for (int n = 0; n < 3; n++) begin
            pstb_cnt[n] = 0; last_pstb[n] = -1; err_cnt[n] = 0; last_err[n] = -1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; eng_wait = 0;
        tick(); tick();
        reset = 1'b0;
    endtask

    initial begin
        int t;
        int exp_ord [6];
        exp_ord = '{100, 101, 102, 100, 101, 102};
        reset = 1'b1; enable = 1'b1; r_stb = '0; phase_out = '0; phase_out_stb = 1'b0;
        for (int n = 0; n < 3; n++) begin r_i[n] = '0; r_q[n] = '0; end
        clear_logs();
        do_reset();
        tick();
        chk("reset_overflow", 32'(overflow), 32'd0);
        chk("reset_pending", 32'(o_pend), 32'd0);

        // Single request from requester 1
        clear_logs();
        t = cyc; r_i[1] = 32'd1000; r_q[1] = '0; r_stb[1] = 1'b1;
        eng_delay = 3; eng_val = 32'h100;
        repeat (10) tick();
        chk("single_issue_cycle", 32'(in_cyc_q.size() > 0 ? in_cyc_q[0] : -1), 32'(t + 2));
        chk("single_issue_i", in_log.size() > 0 ? in_log[0] : 32'hffff_ffff, 32'd1000);
        chk("single_phase", o_phase[1], 32'h100);
        chk("single_result_lat", 32'(last_pstb[1]), 32'(last_out_cyc + 1));
        chk("single_other_stb", 32'(pstb_cnt[0] + pstb_cnt[2]), 32'd0);

        // Contention: two rounds of simultaneous strobes
        do_reset();
        clear_logs();
        for (int n = 0; n < 3; n++) begin r_i[n] = 32'(100 + n); r_q[n] = 32'(n); end
        r_stb = 3'b111; tick();
        repeat (22) tick();
        r_stb = 3'b111; tick();
        repeat (22) tick();
        chk("contend_count", 32'(in_log.size()), 32'd6);
        for (int k = 0; k < in_log.size() && k < 6; k++)
            chk($sformatf("contend_order%0d", k), in_log[k], 32'(exp_ord[k]));
        for (int k = 0; k < 2 && k + 1 < in_cyc_q.size() && k < out_cyc_q.size(); k++)
            chk($sformatf("back_to_back%0d", k), 32'(in_cyc_q[k + 1]), 32'(out_cyc_q[k] + 3));

        // Overflow while serving requester 0
        clear_logs();
        eng_delay = 6;
        r_i[0] = 32'd500; r_q[0] = 32'd5; r_stb[0] = 1'b1; tick();
        tick(); tick();
        r_i[2] = 32'd7; r_q[2] = 32'd70; r_stb[2] = 1'b1; tick();
        r_i[2] = 32'd9; r_q[2] = 32'd90; r_stb[2] = 1'b1; tick();
        repeat (20) tick();
        chk("overflow_flag", 32'(overflow), 32'b100);
        chk("overflow_served_i", in_log.size() > 1 ? in_log[1] : 32'hffff_ffff, 32'd7);

        // No engine response
        clear_logs();
        auto_eng = 1'b0; phase_out_stb = 1'b0;
        r_i[0] = 32'd11; r_i[1] = 32'd22; r_stb = 3'b011; tick();
        repeat (12) tick();
`ifdef PHASE_ARB_TIMEOUT_EN
        chk("timeout_err_cycle", 32'(last_err[0]), 32'(in_cyc_q.size() > 0 ? in_cyc_q[0] + 8 : -1));
        chk("timeout_err_count", 32'(err_cnt[0]), 32'd1);
        chk("timeout_next_issue", in_log.size() > 1 ? in_log[1] : 32'hffff_ffff, 32'd22);
`else
        repeat (40) tick();
        chk("no_timeout_err", 32'(err_cnt[0] + err_cnt[1] + err_cnt[2]), 32'd0);
        chk("no_timeout_issues", 32'(in_log.size()), 32'd1);
        chk("no_timeout_pending", 32'(o_pend[1]), 32'd1);
`endif

        // Reset while BUSY, then a stale engine result
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        clear_logs();
        phase_out = 32'hdead_beef; phase_out_stb = 1'b1; tick();
        phase_out_stb = 1'b0;
        repeat (3) tick();
        chk("rst_busy_stb", 32'(pstb_cnt[0] + pstb_cnt[1] + pstb_cnt[2]), 32'd0);
        chk("rst_busy_overflow", 32'(overflow), 32'd0);
        chk("rst_busy_phase", o_phase[0] | o_phase[1] | o_phase[2] | pin_i, 32'd0);

        // Random traffic with random enable and engine latency
        auto_eng = 1'b1; rand_eng = 1'b1; rand_en = 1'b1;
        for (int c = 0; c < 600; c++) begin
            for (int n = 0; n < 3; n++) begin
                r_stb[n] = ($urandom_range(0, 3) == 0);
                r_i[n]   = $urandom();
                r_q[n]   = $urandom();
            end
            tick();
        end
        rand_en = 1'b0; enable = 1'b1;
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
